// File: rtl/operand_issue_pkg.sv
// Shared sizes and ALU function codes for the operand-issue stage and the ALU behind it.
package operand_issue_pkg;

  localparam int unsigned W    = 32;
  localparam int unsigned NREG = 16;
  localparam int unsigned IdxW = $clog2(NREG);
  localparam int unsigned FinW = 4;

  typedef logic [FinW-1:0] fin_t;

  localparam fin_t FinAdd  = 4'h0;
  localparam fin_t FinSub  = 4'h1;
  localparam fin_t FinAnd  = 4'h2;
  localparam fin_t FinOr   = 4'h3;
  localparam fin_t FinXor  = 4'h4;
  localparam fin_t FinSll  = 4'h5;
  localparam fin_t FinSrl  = 4'h6;
  localparam fin_t FinSra  = 4'h7;
  localparam fin_t FinSlt  = 4'h8;
  localparam fin_t FinSltu = 4'h9;

endpackage

// File: rtl/operand_issue_if.sv
// Upstream issue, write-back and ALU-side bundle signals of the operand-issue stage.
interface operand_issue_if;
  import operand_issue_pkg::*;

  logic            in_valid;
  logic            in_ready;
  fin_t            in_fin;
  logic [IdxW-1:0] in_rs1;
  logic [IdxW-1:0] in_rs2;
  logic [IdxW-1:0] in_rd;

  logic            wb_en;
  logic [IdxW-1:0] wb_addr;
  logic [W-1:0]    wb_data;

  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_a;
  logic [W-1:0]    out_b;
  fin_t            out_fin;
  logic [IdxW-1:0] out_rd;

  modport master (
    output in_valid, in_fin, in_rs1, in_rs2, in_rd,
    output wb_en, wb_addr, wb_data,
    output out_ready,
    input  in_ready,
    input  out_valid, out_a, out_b, out_fin, out_rd
  );

  modport slave (
    input  in_valid, in_fin, in_rs1, in_rs2, in_rd,
    input  wb_en, wb_addr, wb_data,
    input  out_ready,
    output in_ready,
    output out_valid, out_a, out_b, out_fin, out_rd
  );

endinterface

// File: rtl/regfile_2r1w.sv
// Register file with two combinational read ports and one write port; register 0 is hardwired 0.
module regfile_2r1w #(
  parameter int unsigned NREG = operand_issue_pkg::NREG,
  parameter int unsigned W    = operand_issue_pkg::W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] raddr1_i,
  output logic [W-1:0]            rdata1_o,
  input  logic [$clog2(NREG)-1:0] raddr2_i,
  output logic [W-1:0]            rdata2_o,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] waddr_i,
  input  logic [W-1:0]            wdata_i
);

  logic [W-1:0] rf_q [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        rf_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0) ? '0 : rf_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0) ? '0 : rf_q[raddr2_i];

endmodule

// File: rtl/operand_issue.sv
// Operand-issue stage: reads sources with write-back forwarding, tracks pending destinations
// and hands a one-deep operand bundle to the ALU under a valid/ready handshake.
module operand_issue #(
  parameter int unsigned NREG = operand_issue_pkg::NREG,
  parameter int unsigned W    = operand_issue_pkg::W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  operand_issue_if.slave        bus
);
  import operand_issue_pkg::fin_t;

  localparam int unsigned IdxW = $clog2(NREG);

  logic [W-1:0]    rf_rd1, rf_rd2;
  logic [W-1:0]    src1, src2;
  logic            byp1, byp2, hz, ready, accept;

  logic [NREG-1:0] pend_q, pend_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_a_q, out_a_d;
  logic [W-1:0]    out_b_q, out_b_d;
  fin_t            out_fin_q, out_fin_d;
  logic [IdxW-1:0] out_rd_q, out_rd_d;

  regfile_2r1w #(
    .NREG (NREG),
    .W    (W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr1_i (bus.in_rs1),
    .rdata1_o (rf_rd1),
    .raddr2_i (bus.in_rs2),
    .rdata2_o (rf_rd2),
    .we_i     (bus.wb_en),
    .waddr_i  (bus.wb_addr),
    .wdata_i  (bus.wb_data)
  );

  // A same-cycle write-back both releases a hazard and supplies the operand value.
  always_comb begin
    byp1   = bus.wb_en && (bus.wb_addr == bus.in_rs1);
    byp2   = bus.wb_en && (bus.wb_addr == bus.in_rs2);
    hz     = (pend_q[bus.in_rs1] && !byp1) || (pend_q[bus.in_rs2] && !byp2);
    ready  = (!out_valid_q || bus.out_ready) && !hz;
    accept = bus.in_valid && ready;
    src1   = (byp1 && (bus.in_rs1 != '0)) ? bus.wb_data : rf_rd1;
    src2   = (byp2 && (bus.in_rs2 != '0)) ? bus.wb_data : rf_rd2;
  end

  always_comb begin
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_fin_d   = out_fin_q;
    out_rd_d    = out_rd_q;

    if (bus.wb_en) begin
      pend_d[bus.wb_addr] = 1'b0;
    end
    // Applied after the clear so a same-index set wins.
    if (accept && (bus.in_rd != '0)) begin
      pend_d[bus.in_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_a_d     = src1;
      out_b_d     = src2;
      out_fin_d   = bus.in_fin;
      out_rd_d    = bus.in_rd;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_fin_q   <= '0;
      out_rd_q    <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_fin_q   <= out_fin_d;
      out_rd_q    <= out_rd_d;
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_a     = out_a_q;
  assign bus.out_b     = out_b_q;
  assign bus.out_fin   = out_fin_q;
  assign bus.out_rd    = out_rd_q;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed vector table, hand-written hazard/back-pressure/reset
// sequences, then random traffic against an array-based reference model.
module tb_operand_issue;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  operand_issue_if bus ();

  operand_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        iv;
    logic [3:0]  fin, rs1, rs2, rd;
    logic        wbe;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic        ordy;
    logic        e_ready, e_ov;
    logic [31:0] e_a, e_b;
    logic [3:0]  e_fin, e_rd;
  } vec_t;

  vec_t tbl [8];

  // Reference model state
  logic [31:0] m_reg  [16];
  logic        m_pend [16];
  logic        m_ov;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_fin, m_rd;

  function automatic vec_t mk(logic iv, logic [3:0] fin, logic [3:0] rs1, logic [3:0] rs2,
                              logic [3:0] rd, logic wbe, logic [3:0] wba, logic [31:0] wbd,
                              logic ordy, logic er, logic eov, logic [31:0] ea,
                              logic [31:0] eb, logic [3:0] ef, logic [3:0] erd);
    vec_t v;
    v.iv = iv; v.fin = fin; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.wbe = wbe; v.wba = wba; v.wbd = wbd; v.ordy = ordy;
    v.e_ready = er; v.e_ov = eov; v.e_a = ea; v.e_b = eb; v.e_fin = ef; v.e_rd = erd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [3:0] fin, input logic [3:0] rs1,
                       input logic [3:0] rs2, input logic [3:0] rd, input logic wbe,
                       input logic [3:0] wba, input logic [31:0] wbd, input logic ordy);
    bus.in_valid  = iv;
    bus.in_fin    = fin;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_rd     = rd;
    bus.wb_en     = wbe;
    bus.wb_addr   = wba;
    bus.wb_data   = wbd;
    bus.out_ready = ordy;
  endtask

  // Check in_ready for the inputs just applied, then advance past the next rising edge.
  task automatic step(input string nm, input logic er);
    #1;
    chk({nm, ".in_ready"}, 32'(bus.in_ready), 32'(er));
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] f, input logic [3:0] rd);
    chk({nm, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({nm, ".out_a"},     bus.out_a,          a);
    chk({nm, ".out_b"},     bus.out_b,          b);
    chk({nm, ".out_fin"},   32'(bus.out_fin),   32'(f));
    chk({nm, ".out_rd"},    32'(bus.out_rd),    32'(rd));
  endtask

  initial begin
    logic        iv, wbe, ordy, byp1, byp2, hz, er, acc;
    logic [3:0]  fin, rs1, rs2, rd, wba;
    logic [31:0] wbd, v1, v2;

    tbl[0] = mk(0, 4'h0, 0, 0, 0, 1, 1, 32'h0000FFFF, 1, 1, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 4'h0, 0, 0, 0, 1, 2, 32'hFFFF0000, 1, 1, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 4'h2, 1, 2, 3, 0, 0, 0, 1, 1, 1, 32'h0000FFFF, 32'hFFFF0000, 4'h2, 3);
    tbl[3] = mk(1, 4'h1, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 1, 1, 0, 0, 4'h1, 0);
    tbl[4] = mk(1, 4'h4, 0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0000FFFF, 4'h4, 0);
    tbl[5] = mk(0, 4'h0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0000FFFF, 4'h4, 0);
    tbl[6] = mk(1, 4'h5, 3, 0, 6, 0, 0, 0, 1, 0, 0, 0, 32'h0000FFFF, 4'h4, 0);
    tbl[7] = mk(1, 4'h5, 3, 0, 6, 1, 3, 32'h000FFFFF, 1, 1, 1, 32'h000FFFFF, 0, 4'h5, 6);

    // Reset state
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0;
    #12;
    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.in_ready", 32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].iv, tbl[i].fin, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].wbe, tbl[i].wba,
            tbl[i].wbd, tbl[i].ordy);
      step($sformatf("vec%0d", i), tbl[i].e_ready);
      chk_out($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_a, tbl[i].e_b, tbl[i].e_fin,
              tbl[i].e_rd);
    end

    // RAW hazard on rd=7 released by write-back bypass
    drive(1, 4'h3, 0, 0, 7, 0, 0, 0, 1);
    step("raw.issue", 1);
    drive(1, 4'h6, 7, 0, 8, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) step($sformatf("raw.stall%0d", k), 0);
    chk("raw.stall.out_valid", 32'(bus.out_valid), 32'd0);
    drive(1, 4'h6, 7, 0, 8, 1, 7, 32'h000FFFFF, 1);
    step("raw.release", 1);
    chk_out("raw.release", 1, 32'h000FFFFF, 0, 4'h6, 8);

    // Back-pressure for 5 cycles, then back-to-back accept
    drive(1, 4'h7, 1, 2, 9, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step($sformatf("bp%0d", k), 0);
      chk_out($sformatf("bp%0d", k), 1, 32'h000FFFFF, 0, 4'h6, 8);
    end
    drive(1, 4'h7, 1, 2, 9, 0, 0, 0, 1);
    step("b2b", 1);
    chk_out("b2b", 1, 32'h0000FFFF, 32'hFFFF0000, 4'h7, 9);

    // Set and clear of pend[5] in the same cycle: set wins
    drive(1, 4'h0, 0, 0, 5, 1, 5, 32'h12345678, 1);
    step("setclr.issue", 1);
    drive(1, 4'h0, 5, 0, 0, 0, 0, 0, 1);
    step("setclr.stall0", 0);
    step("setclr.stall1", 0);

    // Asynchronous reset in the middle of back-pressure
    drive(1, 4'h2, 1, 2, 0, 0, 0, 0, 1);
    step("arst.issue", 1);
    drive(0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
    step("arst.hold", 0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("arst.async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1, 4'h8, 5, 1, 4, 0, 0, 0, 1);
    step("arst.first", 1);
    chk_out("arst.first", 1, 0, 0, 4'h8, 4);

    // Random traffic against the reference model
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
    m_ov = 0; m_a = 0; m_b = 0; m_fin = 0; m_rd = 0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 400; n++) begin
      iv   = 1'($urandom_range(0, 1));
      fin  = 4'($urandom);
      rs1  = 4'($urandom_range(0, 7));
      rs2  = 4'($urandom_range(0, 7));
      rd   = 4'($urandom_range(0, 7));
      wbe  = ($urandom_range(0, 2) == 0);
      wba  = 4'($urandom_range(0, 7));
      wbd  = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      drive(iv, fin, rs1, rs2, rd, wbe, wba, wbd, ordy);

      byp1 = wbe && (wba == rs1);
      byp2 = wbe && (wba == rs2);
      hz   = (m_pend[rs1] && !byp1) || (m_pend[rs2] && !byp2);
      er   = (!m_ov || ordy) && !hz;
      acc  = iv && er;
      v1   = (rs1 == 0) ? 32'd0 : (byp1 ? wbd : m_reg[rs1]);
      v2   = (rs2 == 0) ? 32'd0 : (byp2 ? wbd : m_reg[rs2]);

      if (wbe && wba != 0) m_reg[wba] = wbd;
      if (wbe) m_pend[wba] = 1'b0;
      if (acc && rd != 0) m_pend[rd] = 1'b1;
      if (acc) begin
        m_ov = 1; m_a = v1; m_b = v2; m_fin = fin; m_rd = rd;
      end else if (ordy) begin
        m_ov = 0;
      end

      step($sformatf("rnd%0d", n), er);
      chk_out($sformatf("rnd%0d", n), m_ov, m_a, m_b, m_fin, m_rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 Parameter: NREG, 16, number of architectural registers; index width is log2(NREG) = 4.
REQ-002 Parameter: W, 32, data width; matches the 32-bit ALU A/B/Y operands.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream instruction present.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 in_fin  input  4  ALU function code, passed through unchanged.
REQ-008 in_rs1, in_rs2, in_rd  input  4 each  source and destination register indices.
REQ-009 wb_en, wb_addr, wb_data  input  1/4/32  ALU result write-back port.
REQ-010 out_valid  output  1  operand bundle valid toward the ALU.
REQ-011 out_ready  input  1  ALU stage consumes the bundle.
REQ-012 out_a, out_b  output  32 each  ALU operands A and B.
REQ-013 out_fin, out_rd  output  4 each  function code and destination index.

Function
REQ-014 Register file SHALL hold NREG x W bits; register 0 SHALL read as 0; writes to register 0 SHALL be ignored.
REQ-015 On a rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] SHALL take wb_data.
REQ-016 Scoreboard: one pending bit per register; register 0 is never pending.
REQ-017 Hazard: hz = (pend[in_rs1] and not bypass1) or (pend[in_rs2] and not bypass2). bypassN = wb_en and wb_addr==in_rsN.
REQ-018 Ready rule: in_ready = (not out_valid or out_ready) and not hz; combinational, no dependence on in_valid.
REQ-019 Accept: occurs when in_valid and in_ready. On accept, out_a/out_b SHALL capture the source values and out_fin/out_rd the inputs. out_valid SHALL then be 1 on the next cycle. Latency is 1 cycle.
REQ-020 Source value: a same-cycle write-back to rsN is forwarded (wb_data); otherwise the register-file contents; register 0 yields 0.
REQ-021 Accept with in_rd!=0 SHALL set pend[in_rd].
REQ-022 wb_en SHALL clear pend[wb_addr].
REQ-023 Set and clear on the same index in the same cycle: set wins.
REQ-024 Consume: if out_ready=1 while out_valid=1 and there is no accept, out_valid SHALL drop to 0. The out_* data SHALL hold its last value.
REQ-025 Back-pressure: while out_valid=1 and out_ready=0, all out_* SHALL remain stable and in_ready=0.
REQ-026 Back-to-back: consume and accept in the same cycle SHALL keep out_valid=1 with the new bundle, giving full throughput.
REQ-027 A write-back arriving while the stage is stalled on hz SHALL release the stall in that same cycle through the bypass.

Reset
REQ-028 rst_n=0 SHALL immediately and asynchronously clear:
- all registers to 0;
- all pending bits;
- out_valid to 0;
- out_a, out_b, out_fin and out_rd to 0.
REQ-029 A reset asserted mid-stall or mid-back-pressure SHALL discard the in-flight bundle. No write-back is lost beyond the reset.
REQ-030 Release: the first accept is possible on the first rising edge after rst_n goes high.

Structure
REQ-031 A shared package SHALL hold:
- the W and NREG defaults;
- the 4-bit ALU function-code constants shared with the ALU;
- the register-index width.
REQ-032 The block SHALL use one sub-module, regfile_2r1w: two combinational read ports, one write port, register-0 masking. Scoreboard, bypass and handshake logic SHALL live in operand_issue.

Verification
REQ-033 Reset, then write-back reg1=0000FFFF and reg2=FFFF0000, then issue fin=0010 rs1=1 rs2=2 rd=3 with out_ready=1. Required: one cycle later out_valid=1, out_a=0000FFFF, out_b=FFFF0000, out_fin=0010, out_rd=3.
REQ-034 Issue with rd=3, then immediately issue with rs1=3 and no write-back. Required: in_ready=0 until wb_en with wb_addr=3 and wb_data=000FFFFF; in that cycle in_ready=1 and out_a=000FFFFF next cycle.
REQ-035 Hold out_ready=0 for 5 cycles with a bundle valid. Required: out_* stable, in_ready=0; then out_ready=1 with a new in_valid gives a back-to-back accept and out_valid stays 1.
REQ-036 Write wb_addr=0 with wb_data=FFFFFFFF, then issue rs1=0 rd=0. Required: out_a=0 and no pending bit set.
REQ-037 Issue with rd=5 in the same cycle as wb_en with wb_addr=5. Required: pend[5]=1 afterwards, so a following rs1=5 issue stalls.
REQ-038 Assert rst_n=0 asynchronously mid back-pressure. Required: out_valid=0 before the next edge; register reads return 0 after release.
